rx_frame_sched: RTL and testbench

Ping-pong frame-buffer scheduler between the Ethernet receive writer and the frame parser. It hands the writer an empty RX bank and launches the parser on each filled bank in arrival order. It holds the single payload RAM until the downstream consumer acknowledges it, and recovers from a hung parser with a watchdog.

---
 rtl/rx_frame_sched_if.sv | 36 +++
 rtl/rx_frame_sched.sv | 142 ++++++++++++++
 tb/tb_rx_frame_sched.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_sched_if.sv
// Handshake bundle between rx_frame_sched and its neighbours: the Ethernet
// RX writer (frame done / bank select), the frame parser (start / done) and
// the payload consumer (valid / ack), plus status counters.
//   master : the scheduler itself (drives rx_bank, parse_*, out_*, counters)
//   slave  : the surrounding blocks (drive rx_frame_*, parse_done/last, out_ack)
interface rx_frame_sched_if #(
    parameter int ADDR_W = 9
);
    logic              rx_frame_done;
    logic [ADDR_W-1:0] rx_frame_words;
    logic              rx_bank;
    logic              rx_stall;
    logic              parse_start;
    logic              parse_bank;
    logic [ADDR_W-1:0] parse_len;
    logic              parse_done;
    logic [ADDR_W-1:0] parse_last;
    logic              out_valid;
    logic [ADDR_W-1:0] out_last;
    logic              out_ack;
    logic [15:0]       drop_count;
    logic [7:0]        timeout_count;
    logic              busy;

    modport master (
        input  rx_frame_done, rx_frame_words, parse_done, parse_last, out_ack,
        output rx_bank, rx_stall, parse_start, parse_bank, parse_len,
               out_valid, out_last, drop_count, timeout_count, busy
    );

    modport slave (
        output rx_frame_done, rx_frame_words, parse_done, parse_last, out_ack,
        input  rx_bank, rx_stall, parse_start, parse_bank, parse_len,
               out_valid, out_last, drop_count, timeout_count, busy
    );
endinterface

// File: rtl/rx_frame_sched.sv
// Ping-pong RX frame-buffer scheduler. Hands the RX writer an empty bank,
// launches the parser on filled banks in arrival order, holds the single
// payload RAM until the consumer acks it, and aborts a hung parse with a
// watchdog.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : rx_frame_sched_if.master (writer, parser and consumer handshakes,
//              drop/timeout counters, busy)
module rx_frame_sched #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    rx_frame_sched_if.master bus
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, PARSING, HOLD} state_t;

    state_t                  state;
    logic [1:0]              full;
    logic [1:0][ADDR_W-1:0]  len;
    logic                    rx_bank;
    logic                    rd_ptr;
    logic                    rx_stall;
    logic                    parse_start;
    logic                    parse_bank;
    logic [ADDR_W-1:0]       parse_len;
    logic                    out_valid;
    logic [ADDR_W-1:0]       out_last;
    logic [15:0]             drop_count;
    logic [7:0]              timeout_count;
    logic                    busy;
    logic [WD_W-1:0]         wd;

    logic                    accept;
    logic                    drop;
    logic                    clr;
    logic [1:0]              full_nxt;
    logic                    rx_bank_nxt;

    // Accept/drop decisions use the registered stall, so a bank being freed
    // in this same cycle still causes a drop. Zero-length frames are ignored
    // outright (never counted as drops).
    always_comb begin
        accept      = bus.rx_frame_done && !rx_stall && (bus.rx_frame_words != '0);
        drop        = bus.rx_frame_done &&  rx_stall && (bus.rx_frame_words != '0);
        clr         = (state == PARSING) && (bus.parse_done || (wd == '0));
        full_nxt    = full;
        if (clr)
            full_nxt[rd_ptr] = 1'b0;
        // An accept always targets the bank opposite the one being cleared,
        // since the cleared bank is full and an accepted bank is empty.
        if (accept)
            full_nxt[rx_bank] = 1'b1;
        rx_bank_nxt = rx_bank ^ accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            full          <= '0;
            len           <= '0;
            rx_bank       <= 1'b0;
            rd_ptr        <= 1'b0;
            rx_stall      <= 1'b0;
            parse_start   <= 1'b0;
            parse_bank    <= 1'b0;
            parse_len     <= '0;
            out_valid     <= 1'b0;
            out_last      <= '0;
            drop_count    <= '0;
            timeout_count <= '0;
            busy          <= 1'b0;
            wd            <= '0;
        end else begin
            full     <= full_nxt;
            rx_bank  <= rx_bank_nxt;
            // Stall mirrors full[] of the bank the writer will own next cycle.
            rx_stall <= full_nxt[rx_bank_nxt];
            if (accept)
                len[rx_bank] <= bus.rx_frame_words;
            if (drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;

            parse_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (full[rd_ptr]) begin
                        state       <= LAUNCH;
                        parse_start <= 1'b1;
                        parse_bank  <= rd_ptr;
                        parse_len   <= len[rd_ptr];
                        busy        <= 1'b1;
                    end
                end
                LAUNCH: begin
                    // TIMEOUT-1 down to 0 spans exactly TIMEOUT PARSING cycles.
                    wd    <= WD_W'(TIMEOUT - 1);
                    state <= PARSING;
                end
                PARSING: begin
                    if (bus.parse_done) begin
                        out_last  <= bus.parse_last;
                        out_valid <= 1'b1;
                        rd_ptr    <= ~rd_ptr;
                        state     <= HOLD;
                    end else if (wd == '0) begin
                        rd_ptr <= ~rd_ptr;
                        if (timeout_count != 8'hFF)
                            timeout_count <= timeout_count + 8'd1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wd <= wd - WD_W'(1);
                    end
                end
                HOLD: begin
                    // Payload RAM belongs to the consumer; no relaunch here.
                    if (bus.out_ack) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_bank       = rx_bank;
    assign bus.rx_stall      = rx_stall;
    assign bus.parse_start   = parse_start;
    assign bus.parse_bank    = parse_bank;
    assign bus.parse_len     = parse_len;
    assign bus.out_valid     = out_valid;
    assign bus.out_last      = out_last;
    assign bus.drop_count    = drop_count;
    assign bus.timeout_count = timeout_count;
    assign bus.busy          = busy;
endmodule

// File: tb/tb_rx_frame_sched.sv
// Bench for rx_frame_sched: directed scenarios plus random traffic, every
// cycle compared against a queue-based reference of pending frames.
module tb_rx_frame_sched;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 16;

    localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_PARSE = 2, PH_HOLD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    rx_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

    rx_frame_sched #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: frames awaiting or undergoing a parse, oldest first.
    int q[$];
    bit m_wr, m_rd, m_pb, m_ov;
    int m_pl, m_ol, m_drops, m_touts, m_phase, m_pcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wr = 0; m_rd = 0; m_pb = 0; m_ov = 0;
        m_pl = 0; m_ol = 0; m_drops = 0; m_touts = 0;
        m_phase = PH_IDLE; m_pcnt = 0;
    endtask

    task automatic drive_idle();
        bus.rx_frame_done  = 1'b0;
        bus.rx_frame_words = '0;
        bus.parse_done     = 1'b0;
        bus.parse_last     = '0;
        bus.out_ack        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: compare outputs, apply inputs, advance the reference.
    task automatic step(input bit d, input int w, input bit pd, input int pl, input bit ak);
        bit stall;
        bit clear;
        chk("rx_bank",       bus.rx_bank,       m_wr);
        chk("rx_stall",      bus.rx_stall,      q.size() == 2);
        chk("parse_start",   bus.parse_start,   m_phase == PH_LAUNCH);
        chk("parse_bank",    bus.parse_bank,    m_pb);
        chk("parse_len",     bus.parse_len,     m_pl);
        chk("out_valid",     bus.out_valid,     m_ov);
        chk("out_last",      bus.out_last,      m_ol);
        chk("drop_count",    bus.drop_count,    m_drops);
        chk("timeout_count", bus.timeout_count, m_touts);
        chk("busy",          bus.busy,          m_phase != PH_IDLE);

        bus.rx_frame_done  = d;
        bus.rx_frame_words = ADDR_W'(w);
        bus.parse_done     = pd;
        bus.parse_last     = ADDR_W'(pl);
        bus.out_ack        = ak;

        stall = (q.size() == 2);
        clear = 0;
        case (m_phase)
            PH_IDLE: if (q.size() > 0) begin
                m_phase = PH_LAUNCH; m_pb = m_rd; m_pl = q[0];
            end
            PH_LAUNCH: begin m_phase = PH_PARSE; m_pcnt = 0; end
            PH_PARSE: begin
                m_pcnt++;
                if (pd) begin
                    m_ol = pl % (1 << ADDR_W); m_ov = 1; clear = 1; m_phase = PH_HOLD;
                end else if (m_pcnt == TIMEOUT) begin
                    clear = 1; m_phase = PH_IDLE;
                    if (m_touts < 255) m_touts++;
                end
            end
            default: if (ak) begin m_ov = 0; m_phase = PH_IDLE; end
        endcase
        if (clear) begin void'(q.pop_front()); m_rd = ~m_rd; end
        if (d && w != 0) begin
            if (!stall) begin q.push_back(w); m_wr = ~m_wr; end
            else if (m_drops < 65535) m_drops++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Reset state
        idle(1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_bank", bus.rx_bank, 0);

        // Single frame: launch 2 cycles after done, bank 0, len 20
        step(1, 20, 0, 0, 0);
        idle(1);
        chk("single_start", bus.parse_start, 1);
        chk("single_len",   bus.parse_len, 20);
        idle(1);
        step(0, 0, 1, 313, 0);
        chk("single_valid", bus.out_valid, 1);
        chk("single_last",  bus.out_last, 313);
        step(0, 0, 0, 0, 1);
        chk("single_ack",   bus.out_valid, 0);

        // Back-to-back, consumer hold, drop-count saturation
        do_reset();
        step(1, 5, 0, 0, 0);     // A -> bank 0
        idle(2);                 // launch, enter PARSING
        step(1, 6, 0, 0, 0);     // B -> bank 1
        step(1, 7, 0, 0, 0);     // C dropped
        chk("b2b_stall", bus.rx_stall, 1);
        chk("b2b_drop",  bus.drop_count, 1);
        step(0, 0, 1, 100, 0);   // A done -> HOLD, bank 1 still full
        idle(50);
        chk("hold_nostart", bus.parse_start, 0);
        for (int i = 0; i < 65540; i++) step(1, 9, 0, 0, 0);
        chk("drop_sat", bus.drop_count, 16'hFFFF);
        step(0, 0, 0, 0, 1);     // ack
        idle(1);
        chk("ack_gap", bus.parse_start, 1);
        chk("b2b_bank1", bus.parse_bank, 1);
        chk("b2b_len", bus.parse_len, 6);
        idle(1);
        step(0, 0, 1, 200, 0);
        step(0, 0, 0, 0, 1);
        idle(3);

        // Zero-length frame
        do_reset();
        step(1, 0, 0, 0, 0);
        idle(2);
        chk("zero_bank", bus.rx_bank, 0);
        chk("zero_busy", bus.busy, 0);

        // Watchdog
        step(1, 33, 0, 0, 0);
        idle(1 + 1 + TIMEOUT);   // launch, then TIMEOUT parsing cycles
        chk("wd_count", bus.timeout_count, 1);
        chk("wd_busy",  bus.busy, 0);
        chk("wd_valid", bus.out_valid, 0);
        chk("wd_freed", bus.rx_stall, 0);

        // Reset mid-PARSING, then a stray parse_done
        step(1, 12, 0, 0, 0);
        idle(4);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 55, 0);
        chk("rst_mid_valid", bus.out_valid, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) == 0,
                 (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 511)),
                 ($urandom % 10) == 0,
                 int'($urandom % 512),
                 ($urandom % 5) == 0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
